// File: rtl/ysyx_23060203_lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states, alignment helper.
package ysyx_23060203_lsu_pkg;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  localparam logic [2:0] ST_B  = 3'b000;
  localparam logic [2:0] ST_H  = 3'b001;
  localparam logic [2:0] ST_W  = 3'b010;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_AR  = 3'd1,
    RD_R   = 3'd2,
    RD_RSP = 3'd3,
    WR_REQ = 3'd4,
    WR_B   = 3'd5,
    WR_RSP = 3'd6
  } lsu_state_e;

  // Half accesses need addr[0]=0, word (and undefined width) accesses need addr[1:0]=0.
  function automatic logic misaligned(input logic [2:0] func, input logic [1:0] lo);
    case (func[1:0])
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060203_lsu_align.sv
// Combinational byte-lane alignment: load shift/extend, store shift and strobe generation.
module ysyx_23060203_lsu_align
  import ysyx_23060203_lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  func,
  input  logic [31:0] m_rdata,
  input  logic [31:0] st_data_in,
  output logic [31:0] ld_data,
  output logic [31:0] st_data,
  output logic [3:0]  st_strb
);

  logic [31:0] shifted;
  logic [3:0]  strb_base;

  assign shifted = m_rdata >> {off, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (func)
      LD_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      LD_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      LD_BU:   ld_data = {24'h0, shifted[7:0]};
      LD_HU:   ld_data = {16'h0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_comb begin
    strb_base = 4'b1111;
    case (func)
      ST_B:    strb_base = 4'b0001;
      ST_H:    strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
  end

  // Shifting within 4 bits truncates lanes that fall off the top of the word.
  assign st_strb = strb_base << off;
  assign st_data = st_data_in << {off, 3'b000};

endmodule

// File: rtl/ysyx_23060203_lsu.sv
// Load/store unit: EXU request/response handshakes to single AXI4-Lite transactions.
// Optional misalignment/bus-error faulting is enabled by YSYX_23060203_LSU_FAULT_EN.
module ysyx_23060203_lsu
  import ysyx_23060203_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        rreq_valid,
  output logic        rreq_ready,
  input  logic [31:0] raddr,
  input  logic [2:0]  rfunc,
  output logic        rres_valid,
  input  logic        rres_ready,
  output logic [31:0] rdata,
  input  logic        wreq_valid,
  output logic        wreq_ready,
  input  logic [31:0] waddr,
  input  logic [2:0]  wfunc,
  input  logic [31:0] wdata,
  output logic        wres_valid,
  input  logic        wres_ready,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        access_fault
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  func_q, func_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        fault_q, fault_d;
  logic [31:0] ld_data;

  ysyx_23060203_lsu_align u_align (
    .off        (addr_q[1:0]),
    .func       (func_q),
    .m_rdata    (m_rdata),
    .st_data_in (wdata_q),
    .ld_data    (ld_data),
    .st_data    (m_wdata),
    .st_strb    (wstrb)
  );

`ifndef YSYX_23060203_LSU_FAULT_EN
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    func_d    = func_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    fault_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rreq_valid) begin
          addr_d  = raddr;
          func_d  = rfunc;
          state_d = RD_AR;
`ifdef YSYX_23060203_LSU_FAULT_EN
          if (misaligned(rfunc, raddr[1:0])) begin
            state_d = RD_RSP;
            rdata_d = 32'h0;
            fault_d = 1'b1;
          end
`endif
        end else if (wreq_valid) begin
          addr_d    = waddr;
          func_d    = wfunc;
          wdata_d   = wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_REQ;
`ifdef YSYX_23060203_LSU_FAULT_EN
          if (misaligned(wfunc, waddr[1:0])) begin
            state_d = WR_RSP;
            fault_d = 1'b1;
          end
`endif
        end
      end
      RD_AR: if (arready) state_d = RD_R;
      RD_R: begin
        if (rvalid) begin
          rdata_d = ld_data;
          state_d = RD_RSP;
`ifdef YSYX_23060203_LSU_FAULT_EN
          fault_d = |rresp;
`endif
        end
      end
      RD_RSP: if (rres_ready) state_d = IDLE;
      WR_REQ: begin
        // Address and data channels complete independently, possibly in the same cycle.
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = WR_B;
      end
      WR_B: begin
        if (bvalid) begin
          state_d = WR_RSP;
`ifdef YSYX_23060203_LSU_FAULT_EN
          fault_d = |bresp;
`endif
        end
      end
      WR_RSP: if (wres_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      addr_q    <= 32'h0;
      func_q    <= 3'h0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      func_q    <= func_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      fault_q   <= fault_d;
    end
  end

  // All bus and response valids decode from flops only, so no AXI input reaches the EXU side.
  assign rreq_ready   = (state_q == IDLE);
  assign wreq_ready   = (state_q == IDLE) && !rreq_valid;
  assign arvalid      = (state_q == RD_AR);
  assign rready       = (state_q == RD_R);
  assign rres_valid   = (state_q == RD_RSP);
  assign awvalid      = (state_q == WR_REQ) && !aw_done_q;
  assign wvalid       = (state_q == WR_REQ) && !w_done_q;
  assign bready       = (state_q == WR_B);
  assign wres_valid   = (state_q == WR_RSP);
  assign araddr       = addr_q;
  assign awaddr       = addr_q;
  assign rdata        = rdata_q;
  assign access_fault = fault_q;

endmodule

// File: tb/tb_ysyx_23060203_lsu.sv
// Directed self-checking bench for ysyx_23060203_lsu; fault cases run when YSYX_23060203_LSU_FAULT_EN is defined.
module tb_ysyx_23060203_lsu;

`ifdef YSYX_23060203_LSU_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rreq_valid = 1'b0, rreq_ready;
  logic [31:0] raddr = '0;
  logic [2:0]  rfunc = '0;
  logic        rres_valid, rres_ready = 1'b0;
  logic [31:0] rdata;
  logic        wreq_valid = 1'b0, wreq_ready;
  logic [31:0] waddr = '0, wdata = '0;
  logic [2:0]  wfunc = '0;
  logic        wres_valid, wres_ready = 1'b0;
  logic [31:0] araddr, awaddr, m_wdata;
  logic [31:0] m_rdata = '0;
  logic        arvalid, arready = 1'b0;
  logic [1:0]  rresp = '0, bresp = '0;
  logic        rvalid = 1'b0, rready;
  logic        awvalid, awready = 1'b0;
  logic [3:0]  wstrb;
  logic        wvalid, wready = 1'b0;
  logic        bvalid = 1'b0, bready;
  logic        access_fault;

  int checks = 0;
  int errors = 0;
  int aw_hs = 0;
  int w_hs = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (awvalid && awready) aw_hs <= aw_hs + 1;
    if (wvalid && wready) w_hs <= w_hs + 1;
  end

  ysyx_23060203_lsu dut (
    .clk(clk), .rstn(rstn),
    .rreq_valid(rreq_valid), .rreq_ready(rreq_ready), .raddr(raddr), .rfunc(rfunc),
    .rres_valid(rres_valid), .rres_ready(rres_ready), .rdata(rdata),
    .wreq_valid(wreq_valid), .wreq_ready(wreq_ready), .waddr(waddr), .wfunc(wfunc), .wdata(wdata),
    .wres_valid(wres_valid), .wres_ready(wres_ready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .m_rdata(m_rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .m_wdata(m_wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .access_fault(access_fault)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Zero-wait read; response accepted the cycle it appears.
  task automatic do_read(input string tag, input logic [31:0] a, input logic [2:0] f,
                         input logic [31:0] d, input logic [1:0] rsp, input logic [31:0] exp);
    chk({tag, "_rreq_ready"}, {31'h0, rreq_ready}, 32'h1);
    rreq_valid = 1'b1; raddr = a; rfunc = f;
    arready = 1'b1; rvalid = 1'b1; m_rdata = d; rresp = rsp;
    tick();
    rreq_valid = 1'b0;
    chk({tag, "_arvalid"}, {31'h0, arvalid}, 32'h1);
    chk({tag, "_araddr"}, araddr, a);
    tick();
    chk({tag, "_rready"}, {31'h0, rready}, 32'h1);
    tick();
    chk({tag, "_rres_valid"}, {31'h0, rres_valid}, 32'h1);
    chk({tag, "_rdata"}, rdata, exp);
    chk({tag, "_fault"}, {31'h0, access_fault}, {31'h0, FAULT_EN && (rsp != 2'b00)});
    rres_ready = 1'b1;
    tick();
    rres_ready = 1'b0; arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
    chk({tag, "_rres_done"}, {31'h0, rres_valid}, 32'h0);
    $display("read  %s addr=%h func=%0d data=%h -> rdata=%h", tag, a, f, d, exp);
  endtask

  // Zero-wait write with both channels ready.
  task automatic do_write(input string tag, input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] wd, input logic [1:0] rsp,
                          input logic [31:0] exp_d, input logic [3:0] exp_s);
    chk({tag, "_wreq_ready"}, {31'h0, wreq_ready}, 32'h1);
    wreq_valid = 1'b1; waddr = a; wfunc = f; wdata = wd;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = rsp;
    tick();
    wreq_valid = 1'b0;
    chk({tag, "_awvalid"}, {31'h0, awvalid}, 32'h1);
    chk({tag, "_wvalid"}, {31'h0, wvalid}, 32'h1);
    chk({tag, "_awaddr"}, awaddr, a);
    chk({tag, "_m_wdata"}, m_wdata, exp_d);
    chk({tag, "_wstrb"}, {28'h0, wstrb}, {28'h0, exp_s});
    tick();
    chk({tag, "_bready"}, {31'h0, bready}, 32'h1);
    tick();
    chk({tag, "_wres_valid"}, {31'h0, wres_valid}, 32'h1);
    chk({tag, "_fault"}, {31'h0, access_fault}, {31'h0, FAULT_EN && (rsp != 2'b00)});
    wres_ready = 1'b1;
    tick();
    wres_ready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    chk({tag, "_wres_done"}, {31'h0, wres_valid}, 32'h0);
    $display("write %s addr=%h func=%0d data=%h -> m_wdata=%h wstrb=%b", tag, a, f, wd, exp_d, exp_s);
  endtask

  initial begin
    int aw0, w0;
    tick(); tick();
    chk("rst_arvalid", {31'h0, arvalid}, 32'h0);
    chk("rst_bready", {31'h0, bready}, 32'h0);
    chk("rst_rres_valid", {31'h0, rres_valid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_fault", {31'h0, access_fault}, 32'h0);
    chk("rst_wreq_ready", {31'h0, wreq_ready}, 32'h1);
    rstn = 1'b1;
    tick();

    // LB with latency check and a slow consumer holding rres_ready low.
    rreq_valid = 1'b1; raddr = 32'h8000_0003; rfunc = 3'b000;
    arready = 1'b1; rvalid = 1'b1; m_rdata = 32'h80AA_BBCC;
    tick();
    rreq_valid = 1'b0;
    chk("lb_c1_arvalid", {31'h0, arvalid}, 32'h1);
    chk("lb_c1_rres_valid", {31'h0, rres_valid}, 32'h0);
    tick();
    chk("lb_c2_rready", {31'h0, rready}, 32'h1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("lb_hold_rres_valid", {31'h0, rres_valid}, 32'h1);
      chk("lb_hold_rdata", rdata, 32'hFFFF_FF80);
      chk("lb_hold_rreq_ready", {31'h0, rreq_ready}, 32'h0);
      m_rdata = 32'h0BAD_0BAD;
      tick();
    end
    rres_ready = 1'b1;
    tick();
    rres_ready = 1'b0; arready = 1'b0; rvalid = 1'b0;
    chk("lb_done_rreq_ready", {31'h0, rreq_ready}, 32'h1);
    $display("read  LB addr=80000003 data=80aabbcc -> rdata=ffffff80");

    do_read("LHU", 32'h8000_0002, 3'b101, 32'h1234_5678, 2'b00, 32'h0000_1234);
    do_read("LH", 32'h8000_0000, 3'b001, 32'h0000_8001, 2'b00, 32'hFFFF_8001);
    do_read("LBU", 32'h8000_0001, 3'b100, 32'h0000_F000, 2'b00, 32'h0000_00F0);
    do_read("LW_err", 32'h8000_0010, 3'b010, 32'hCAFE_F00D, 2'b10, 32'hCAFE_F00D);

    // Simultaneous requests: read wins.
    rreq_valid = 1'b1; raddr = 32'h8000_0020; rfunc = 3'b010;
    wreq_valid = 1'b1; waddr = 32'h8000_0030; wfunc = 3'b010;
    #1;
    chk("both_wreq_ready", {31'h0, wreq_ready}, 32'h0);
    chk("both_rreq_ready", {31'h0, rreq_ready}, 32'h1);
    tick();
    rreq_valid = 1'b0; wreq_valid = 1'b0;
    chk("both_arvalid", {31'h0, arvalid}, 32'h1);
    chk("both_awvalid", {31'h0, awvalid}, 32'h0);
    arready = 1'b1; rvalid = 1'b1; m_rdata = 32'h1;
    tick(); tick();
    rres_ready = 1'b1;
    tick();
    rres_ready = 1'b0; arready = 1'b0; rvalid = 1'b0;
    $display("read  both-valid arbitration addr=80000020");

    do_write("SH", 32'h8000_0002, 3'b001, 32'h0000_BEEF, 2'b00, 32'hBEEF_0000, 4'b1100);
    do_write("SB", 32'h8000_0001, 3'b000, 32'h0000_00AB, 2'b00, 32'h0000_AB00, 4'b0010);
    do_write("SW_err", 32'h8000_0004, 3'b010, 32'h1122_3344, 2'b10, 32'h1122_3344, 4'b1111);

    // SH with awready three cycles behind wready.
    aw0 = aw_hs; w0 = w_hs;
    wreq_valid = 1'b1; waddr = 32'h8000_0002; wfunc = 3'b001; wdata = 32'h0000_BEEF;
    wready = 1'b1; awready = 1'b0;
    tick();
    wreq_valid = 1'b0;
    chk("dly_c1_awvalid", {31'h0, awvalid}, 32'h1);
    chk("dly_c1_wvalid", {31'h0, wvalid}, 32'h1);
    tick();
    chk("dly_c2_wvalid", {31'h0, wvalid}, 32'h0);
    chk("dly_c2_awvalid", {31'h0, awvalid}, 32'h1);
    chk("dly_c2_m_wdata", m_wdata, 32'hBEEF_0000);
    tick();
    chk("dly_c3_awvalid", {31'h0, awvalid}, 32'h1);
    tick();
    awready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    chk("dly_bready", {31'h0, bready}, 32'h1);
    chk("dly_awvalid_off", {31'h0, awvalid}, 32'h0);
    chk("dly_aw_hs", aw_hs - aw0, 32'd1);
    chk("dly_w_hs", w_hs - w0, 32'd1);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("dly_wres_valid", {31'h0, wres_valid}, 32'h1);
    wres_ready = 1'b1;
    tick();
    wres_ready = 1'b0;
    $display("write SH delayed-aw aw_hs=%0d w_hs=%0d", aw_hs - aw0, w_hs - w0);

    // Reset while waiting in WR_B.
    wreq_valid = 1'b1; waddr = 32'h8000_0008; wfunc = 3'b010; wdata = 32'h5555_AAAA;
    awready = 1'b1; wready = 1'b1;
    tick();
    wreq_valid = 1'b0;
    tick();
    chk("rstwb_bready_pre", {31'h0, bready}, 32'h1);
    rstn = 1'b0; awready = 1'b0; wready = 1'b0;
    tick();
    chk("rstwb_bready", {31'h0, bready}, 32'h0);
    chk("rstwb_wres_valid", {31'h0, wres_valid}, 32'h0);
    chk("rstwb_idle", {31'h0, rreq_ready}, 32'h1);
    rstn = 1'b1;
    tick();
    $display("reset in WR_B abandons write");
    do_read("LW_after_rst", 32'h8000_0004, 3'b010, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF);

`ifdef YSYX_23060203_LSU_FAULT_EN
    rreq_valid = 1'b1; raddr = 32'h8000_0001; rfunc = 3'b010;
    arready = 1'b1; rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF;
    tick();
    rreq_valid = 1'b0;
    chk("mis_arvalid", {31'h0, arvalid}, 32'h0);
    chk("mis_rres_valid", {31'h0, rres_valid}, 32'h1);
    chk("mis_fault", {31'h0, access_fault}, 32'h1);
    chk("mis_rdata", rdata, 32'h0);
    tick();
    chk("mis_fault_pulse", {31'h0, access_fault}, 32'h0);
    rres_ready = 1'b1;
    tick();
    rres_ready = 1'b0; arready = 1'b0; rvalid = 1'b0;
    chk("mis_done", {31'h0, rres_valid}, 32'h0);
    $display("read  misaligned LW addr=80000001 -> fault");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
